// File: rtl/mipi_rffe_slave_if.sv
// Bundles the RFFE wire pair and the register-file side of the RFFE slave.
interface mipi_rffe_slave_if;
   logic       sclk_i;
   logic       sdata_i;
   logic       sdata_o;
   logic       sdata_oe;
   logic       reg_wr_vd;
   logic [4:0] reg_wr_addr;
   logic [7:0] reg_wr_data;
   logic [4:0] reg_rd_addr;
   logic [7:0] reg_rd_data;
   logic       frm_err;

   modport slave (
      input  sclk_i, sdata_i, reg_rd_data,
      output sdata_o, sdata_oe, reg_wr_vd, reg_wr_addr, reg_wr_data, reg_rd_addr, frm_err
   );

   modport master (
      output sclk_i, sdata_i, reg_rd_data,
      input  sdata_o, sdata_oe, reg_wr_vd, reg_wr_addr, reg_wr_data, reg_rd_addr, frm_err
   );
endinterface

// File: rtl/mipi_rffe_slave.sv
// MIPI RFFE slave: oversampled SSC detection, Register Write / Read / Register-0 Write
// decoding, with a register-file export and SDATA drive during read data.
module mipi_rffe_slave #(
   parameter logic [3:0]  USID     = 4'hA,
   parameter int unsigned SYNC_NFF = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   mipi_rffe_slave_if.slave  bus
);
   localparam int unsigned CNT_W = 4;
   localparam int unsigned SH_W  = 12;
   localparam int unsigned TX_W  = 9;

   typedef enum logic [2:0] {IDLE, CMD, WDATA, RPARK, RDATA, EPARK} state_t;

   logic [SYNC_NFF-1:0] sclk_sync, sdata_sync;
   logic                sclk_p, sdata_p;
   logic                sclk_s, sdata_s;
   logic                sclk_rise, sclk_fall, sdata_rise, sdata_fall;
   logic                ssc_c;

   state_t              state_q, state_n;
   logic [CNT_W-1:0]    cnt_q, cnt_n;
   logic [SH_W-1:0]     sh_q, sh_n;
   logic [4:0]          waddr_q, waddr_n;
   logic [TX_W-1:0]     tx_q, tx_n;
   logic                arm_q, arm_n;

   logic                sdo_q, sdo_n, oe_q, oe_n;
   logic                wr_vd_q, wr_vd_n, err_q, err_n;
   logic [4:0]          wr_addr_q, wr_addr_n, rd_addr_q, rd_addr_n;
   logic [7:0]          wr_data_q, wr_data_n;

   logic [12:0]         cmd_frame;
   logic [8:0]          dat_frame;
   logic [3:0]          sa;
   logic [7:0]          cmd;

   // Input synchronisers plus one-sample history for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync  <= '0;
         sdata_sync <= '0;
         sclk_p     <= 1'b0;
         sdata_p    <= 1'b0;
      end else begin
         sclk_sync  <= {sclk_sync[SYNC_NFF-2:0], bus.sclk_i};
         sdata_sync <= {sdata_sync[SYNC_NFF-2:0], bus.sdata_i};
         sclk_p     <= sclk_s;
         sdata_p    <= sdata_s;
      end
   end

   assign sclk_s     = sclk_sync[SYNC_NFF-1];
   assign sdata_s    = sdata_sync[SYNC_NFF-1];
   assign sclk_rise  = sclk_s & ~sclk_p;
   assign sclk_fall  = ~sclk_s & sclk_p;
   assign sdata_rise = sdata_s & ~sdata_p;
   assign sdata_fall = ~sdata_s & sdata_p;

   // SSC completes on an armed SDATA fall with SCLK low for both samples.
   assign ssc_c = arm_q & sdata_fall & ~sclk_s & ~sclk_p & ~oe_q;

   assign cmd_frame = {sh_q, sdata_s};
   assign dat_frame = {sh_q[7:0], sdata_s};
   assign sa        = cmd_frame[12:9];
   assign cmd       = cmd_frame[8:1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sh_q      <= '0;
         waddr_q   <= '0;
         tx_q      <= '0;
         arm_q     <= 1'b0;
         sdo_q     <= 1'b0;
         oe_q      <= 1'b0;
         wr_vd_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         sh_q      <= sh_n;
         waddr_q   <= waddr_n;
         tx_q      <= tx_n;
         arm_q     <= arm_n;
         sdo_q     <= sdo_n;
         oe_q      <= oe_n;
         wr_vd_q   <= wr_vd_n;
         wr_addr_q <= wr_addr_n;
         wr_data_q <= wr_data_n;
         rd_addr_q <= rd_addr_n;
         err_q     <= err_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      sh_n      = sh_q;
      waddr_n   = waddr_q;
      tx_n      = tx_q;
      arm_n     = arm_q;
      sdo_n     = sdo_q;
      oe_n      = oe_q;
      wr_vd_n   = 1'b0;
      wr_addr_n = wr_addr_q;
      wr_data_n = wr_data_q;
      rd_addr_n = rd_addr_q;
      err_n     = 1'b0;

      // Arm only on an SDATA rise inside a quiet SCLK-low window; any SCLK activity disarms.
      if (oe_q || sclk_s || sclk_p) arm_n = 1'b0;
      else if (sdata_rise)          arm_n = 1'b1;
      else if (sdata_fall)          arm_n = 1'b0;

      if (ssc_c) begin
         state_n = CMD;
         cnt_n   = '0;
      end else begin
         case (state_q)
            IDLE: ;
            CMD: begin
               if (sclk_fall) begin
                  sh_n  = {sh_q[SH_W-2:0], sdata_s};
                  cnt_n = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(12)) begin
                     cnt_n   = '0;
                     state_n = IDLE;
                     if (!(^cmd_frame)) begin
                        err_n = 1'b1;
                     end else if (sa == USID || sa == 4'h0) begin
                        if (cmd[7]) begin
                           wr_vd_n   = 1'b1;
                           wr_addr_n = 5'd0;
                           wr_data_n = {1'b0, cmd[6:0]};
                        end else if (cmd[7:5] == 3'b010) begin
                           waddr_n = cmd[4:0];
                           state_n = WDATA;
                        end else if (cmd[7:5] == 3'b011 && sa == USID) begin
                           rd_addr_n = cmd[4:0];
                           state_n   = RPARK;
                        end
                     end
                  end
               end
            end
            WDATA: begin
               if (sclk_fall) begin
                  sh_n  = {sh_q[SH_W-2:0], sdata_s};
                  cnt_n = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(8)) begin
                     cnt_n   = '0;
                     state_n = IDLE;
                     if (^dat_frame) begin
                        wr_vd_n   = 1'b1;
                        wr_addr_n = waddr_q;
                        wr_data_n = dat_frame[8:1];
                     end else begin
                        err_n = 1'b1;
                     end
                  end
               end
            end
            RPARK: begin
               // End-of-park fall: capture read data with its odd parity bit.
               if (sclk_fall) begin
                  tx_n    = {bus.reg_rd_data, ~^bus.reg_rd_data};
                  cnt_n   = '0;
                  state_n = RDATA;
               end
            end
            RDATA: begin
               if (sclk_rise) begin
                  oe_n  = 1'b1;
                  sdo_n = tx_q[TX_W-1];
                  tx_n  = {tx_q[TX_W-2:0], 1'b0};
                  cnt_n = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(8)) begin
                     cnt_n   = '0;
                     state_n = EPARK;
                  end
               end
            end
            EPARK: begin
               // cnt marks that the park rise has been driven; the trailing parity fall is skipped.
               if (sclk_rise) begin
                  sdo_n = 1'b0;
                  oe_n  = 1'b1;
                  cnt_n = CNT_W'(1);
               end else if (sclk_fall && cnt_q == CNT_W'(1)) begin
                  oe_n    = 1'b0;
                  cnt_n   = '0;
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign bus.sdata_o     = sdo_q;
   assign bus.sdata_oe    = oe_q;
   assign bus.reg_wr_vd   = wr_vd_q;
   assign bus.reg_wr_addr = wr_addr_q;
   assign bus.reg_wr_data = wr_data_q;
   assign bus.reg_rd_addr = rd_addr_q;
   assign bus.frm_err     = err_q;
endmodule

// File: tb/tb_mipi_rffe_slave.sv
// Randomised bench for mipi_rffe_slave: an RFFE master driver plus a frame-level outcome model.
module tb_mipi_rffe_slave;
   localparam logic [3:0] USID = 4'hA;

   logic clk;
   logic rst_n;
   logic m_sda;
   logic glitch_en, glitch_val;
   logic [7:0] rf [32];

   int n_cmp, n_bad;
   int wr_cnt, err_cnt, oe_cnt;
   logic [4:0] last_addr, held_addr, rd_addr_seen;
   logic [7:0] last_data, held_data;

   mipi_rffe_slave_if bus();

   mipi_rffe_slave #(.USID(USID), .SYNC_NFF(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Open-drain-like bus: slave drives when enabled, bench can force a glitch.
   assign bus.sdata_i = glitch_en ? glitch_val : (bus.sdata_oe ? bus.sdata_o : m_sda);

   // External register file with one-clock read latency.
   always @(posedge clk) bus.reg_rd_data <= rf[bus.reg_rd_addr];

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.reg_wr_vd) begin
            wr_cnt++;
            last_addr = bus.reg_wr_addr;
            last_data = bus.reg_wr_data;
         end
         if (bus.frm_err)  err_cnt++;
         if (bus.sdata_oe) oe_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic half();
      idle(4);
   endtask

   task automatic ssc();
      bus.sclk_i = 1'b0;
      m_sda = 1'b0; half();
      m_sda = 1'b1; half();
      m_sda = 1'b0; half();
   endtask

   task automatic send_bit(input logic b);
      bus.sclk_i = 1'b1; m_sda = b; half();
      bus.sclk_i = 1'b0; half();
   endtask

   task automatic send_cmd(input logic [3:0] sa, input logic [7:0] c, input bit flip);
      logic [12:0] f;
      f = {sa, c, (~^{sa, c}) ^ flip};
      for (int i = 12; i >= 0; i--) send_bit(f[i]);
   endtask

   task automatic send_data(input logic [7:0] d, input bit flip, input int nbits);
      logic [8:0] f;
      f = {d, (~^d) ^ flip};
      for (int i = 8; i > 8 - nbits; i--) send_bit(f[i]);
   endtask

   task automatic read_frame(input int glitch_at, output logic [8:0] bits);
      bits = '0;
      send_bit(1'b0);
      for (int i = 0; i < 9; i++) begin
         bus.sclk_i = 1'b1; half();
         bits[8-i] = bus.sdata_i;
         if (i == 0) rd_addr_seen = bus.reg_rd_addr;
         bus.sclk_i = 1'b0; half();
         if (i == glitch_at) begin
            glitch_en = 1'b1; glitch_val = 1'b0; idle(3);
            glitch_val = 1'b1; idle(4);
            glitch_val = 1'b0; idle(4);
            glitch_en = 1'b0; idle(2);
         end
      end
      bus.sclk_i = 1'b1; half();
      bus.sclk_i = 1'b0; half();
   endtask

   // Frame-level model: outcome follows from parity, SA and command class only.
   task automatic txn(input logic [3:0] sa, input logic [7:0] c, input bit fc,
                      input logic [7:0] d, input bit fd, input int glitch_at);
      bit hit, rd_ok;
      int exp_wr, exp_err;
      logic [4:0] ea;
      logic [7:0] ed;
      logic [8:0] rb;
      hit = (sa == USID) || (sa == 4'h0);
      exp_wr = 0; exp_err = 0; rd_ok = 1'b0; ea = '0; ed = '0; rb = '0;
      if (fc) exp_err = 1;
      else if (hit) begin
         if (c[7]) begin exp_wr = 1; ea = 5'd0; ed = {1'b0, c[6:0]}; end
         else if (c[7:5] == 3'b010) begin
            if (fd) exp_err = 1;
            else begin exp_wr = 1; ea = c[4:0]; ed = d; end
         end else if (c[7:5] == 3'b011 && sa == USID) rd_ok = 1'b1;
      end
      wr_cnt = 0; err_cnt = 0; oe_cnt = 0;
      ssc();
      send_cmd(sa, c, fc);
      if (c[7:5] == 3'b010)      send_data(d, fd, 9);
      else if (c[7:5] == 3'b011) read_frame(rd_ok ? glitch_at : -1, rb);
      idle(8);
      chk("wr_count", 32'(wr_cnt), 32'(exp_wr));
      chk("err_count", 32'(err_cnt), 32'(exp_err));
      if (exp_wr != 0) begin
         chk("wr_addr", 32'(last_addr), 32'(ea));
         chk("wr_data", 32'(last_data), 32'(ed));
         held_addr = ea; held_data = ed;
      end else begin
         chk("wr_hold", 32'({bus.reg_wr_addr, bus.reg_wr_data}), 32'({held_addr, held_data}));
      end
      if (c[7:5] == 3'b011) begin
         if (rd_ok) begin
            chk("rd_addr", 32'(rd_addr_seen), 32'(c[4:0]));
            chk("rd_bits", 32'(rb), 32'({rf[c[4:0]], ~^rf[c[4:0]]}));
         end
         chk("rd_drove", 32'(oe_cnt != 0), 32'(rd_ok));
      end
      chk("oe_idle", 32'(bus.sdata_oe), 32'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_sdata_o", 32'(bus.sdata_o), 32'd0);
      chk("rst_sdata_oe", 32'(bus.sdata_oe), 32'd0);
      chk("rst_wr_vd", 32'(bus.reg_wr_vd), 32'd0);
      chk("rst_wr_addr", 32'(bus.reg_wr_addr), 32'd0);
      chk("rst_wr_data", 32'(bus.reg_wr_data), 32'd0);
      chk("rst_rd_addr", 32'(bus.reg_rd_addr), 32'd0);
      chk("rst_frm_err", 32'(bus.frm_err), 32'd0);
   endtask

   initial begin
      logic [3:0] sa;
      logic [7:0] c;
      int kind, g;
      n_cmp = 0; n_bad = 0;
      wr_cnt = 0; err_cnt = 0; oe_cnt = 0;
      held_addr = '0; held_data = '0; last_addr = '0; last_data = '0; rd_addr_seen = '0;
      glitch_en = 1'b0; glitch_val = 1'b0;
      m_sda = 1'b0; bus.sclk_i = 1'b0;
      for (int i = 0; i < 32; i++) rf[i] = 8'($urandom);
      rst_n = 1'b0;
      idle(5);
      chk_reset_outputs();
      rst_n = 1'b1;
      idle(4);

      // Register write.
      txn(USID, 8'h45, 1'b0, 8'h3C, 1'b0, -1);

      // Reset asserted in the middle of the data phase drops the frame.
      wr_cnt = 0; err_cnt = 0;
      ssc();
      send_cmd(USID, 8'h46, 1'b0);
      send_data(8'h99, 1'b0, 4);
      rst_n = 1'b0;
      idle(3);
      chk_reset_outputs();
      rst_n = 1'b1;
      held_addr = '0; held_data = '0;
      idle(4);
      chk("rst_no_write", 32'(wr_cnt), 32'd0);
      txn(USID, 8'h45, 1'b0, 8'h3C, 1'b0, -1);

      // Register-0 write: broadcast accepted, foreign SA ignored.
      txn(4'h0, 8'hAA, 1'b0, 8'h00, 1'b0, -1);
      txn(4'h3, 8'hAA, 1'b0, 8'h00, 1'b0, -1);

      // Register read.
      rf[7] = 8'h81;
      txn(USID, 8'h67, 1'b0, 8'h00, 1'b0, -1);
      txn(4'h0, 8'h67, 1'b0, 8'h00, 1'b0, -1);

      // Parity errors on data and on command.
      txn(USID, 8'h45, 1'b0, 8'h3C, 1'b1, -1);
      txn(USID, 8'h45, 1'b1, 8'h3C, 1'b0, -1);

      // Second SSC aborts a write in progress; the new command is decoded.
      ssc();
      send_cmd(USID, 8'h4C, 1'b0);
      send_data(8'hF0, 1'b0, 3);
      txn(USID, 8'h43, 1'b0, 8'h5A, 1'b0, -1);

      // SSC-shaped glitch while the slave drives read data.
      rf[9] = 8'hC5;
      txn(USID, 8'h69, 1'b0, 8'h00, 1'b0, 3);

      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0:       c = {3'b010, 5'($urandom)};
            1:       c = {1'b1, 7'($urandom)};
            2:       c = {3'b011, 5'($urandom)};
            default: c = 8'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0, 2:    sa = USID;
            1:       sa = 4'h0;
            default: sa = 4'($urandom);
         endcase
         g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
         txn(sa, c, $urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 7) == 0, g);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
